// File: rtl/mybus_rx_pkg.sv
// MyBus receive deframer: shared types and defaults.
// FSM state encoding, default geometry and header bit value.
package mybus_rx_pkg;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2
  } rx_state_e;

  localparam int unsigned RX_WIDTH_DEF   = 8;
  localparam int unsigned RX_GAP_MAX_DEF = 15;
  localparam logic        RX_HDR_BIT     = 1'b1;

endpackage

// File: rtl/mybus_rx_deframer_if.sv
// MyBus receive deframer bus bundle.
// master drives serial input and consumer ready; slave is the deframer.
interface mybus_rx_deframer_if
  import mybus_rx_pkg::*;
#(
  parameter int unsigned WIDTH = RX_WIDTH_DEF
);

  logic             isolate;
  logic             execute;
  logic             dataTx;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             rx_perr;
  logic             frame_err;
  logic             overrun;

  modport master (
    output isolate, execute, dataTx, rx_ready,
    input  rx_data, rx_valid, rx_perr, frame_err, overrun
  );

  modport slave (
    input  isolate, execute, dataTx, rx_ready,
    output rx_data, rx_valid, rx_perr, frame_err, overrun
  );

endinterface

// File: rtl/mybus_rx_gap_timer.sv
// Inter-bit gap timer: counts idle cycles inside a frame.
// expired flags the cycle on which the count would reach GAP_MAX.
module mybus_rx_gap_timer
  import mybus_rx_pkg::*;
#(
  parameter int unsigned GAP_MAX = RX_GAP_MAX_DEF
) (
  input  logic ck,
  input  logic arst,
  input  logic load,
  input  logic enable,
  output logic expired
);

  localparam int unsigned GW = $clog2(GAP_MAX + 1);

  logic [GW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign expired = enable && !load &&
                   (cnt_q == GW'(GAP_MAX - 1));

  always_ff @(posedge ck) begin
    if (!arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mybus_rx_deframer.sv
// MyBus receive deframer: serial frames to WIDTH-bit words
// with parity flag, gap/isolation abort and a one-word holding reg.
module mybus_rx_deframer
  import mybus_rx_pkg::*;
#(
  parameter int unsigned WIDTH   = RX_WIDTH_DEF,
  parameter int unsigned GAP_MAX = RX_GAP_MAX_DEF
) (
  input  logic                ck,
  input  logic                arst,
  mybus_rx_deframer_if.slave  bus
);

  localparam int unsigned BW = $clog2(WIDTH + 1);

  rx_state_e        state_q, state_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             perr_q, perr_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  logic busy, take, expired;
  logic tmr_load, tmr_en;

  assign busy     = (state_q != RX_IDLE);
  assign take     = !valid_q || bus.rx_ready;
  assign tmr_load = !busy || bus.execute || bus.isolate;
  assign tmr_en   = busy && !bus.execute && !bus.isolate;

  mybus_rx_gap_timer #(
    .GAP_MAX (GAP_MAX)
  ) u_gap (
    .ck      (ck),
    .arst    (arst),
    .load    (tmr_load),
    .enable  (tmr_en),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    perr_d  = perr_q;
    valid_d = valid_q && !bus.rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    if (bus.isolate) begin
      ferr_d  = busy;
      state_d = RX_IDLE;
    end else begin
      unique case (state_q)
        RX_IDLE: begin
          if (bus.execute && bus.dataTx == RX_HDR_BIT) begin
            state_d = RX_DATA;
            bcnt_d  = '0;
          end
        end
        RX_DATA: begin
          if (bus.execute) begin
            for (int i = 0; i < WIDTH; i++) begin
              if (bcnt_q == BW'(i)) sh_d[i] = bus.dataTx;
            end
            bcnt_d = bcnt_q + 1'b1;
            if (bcnt_q == BW'(WIDTH - 1)) state_d = RX_PARITY;
          end else if (expired) begin
            ferr_d  = 1'b1;
            state_d = RX_IDLE;
          end
        end
        RX_PARITY: begin
          if (bus.execute) begin
            state_d = RX_IDLE;
            if (take) begin
              valid_d = 1'b1;
              data_d  = sh_q;
              perr_d  = (^sh_q) ^ bus.dataTx;
            end else begin
              ovr_d = 1'b1;
            end
          end else if (expired) begin
            ferr_d  = 1'b1;
            state_d = RX_IDLE;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (!arst) begin
      state_q <= RX_IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_perr   = perr_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;

endmodule

// File: tb/tb_mybus_rx_deframer.sv
// Bench for mybus_rx_deframer: directed scenarios plus
// randomized frames against a transaction-level holding model.
module tb_mybus_rx_deframer;
  import mybus_rx_pkg::*;

  localparam int W   = 8;
  localparam int GAP = 15;

  logic ck;
  logic arst;
  int   passed;
  int   total;

  mybus_rx_deframer_if #(.WIDTH(W)) bus ();

  mybus_rx_deframer #(
    .WIDTH   (W),
    .GAP_MAX (GAP)
  ) dut (
    .ck   (ck),
    .arst (arst),
    .bus  (bus.slave)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic strobe(input logic b);
    bus.execute = 1'b1;
    bus.dataTx  = b;
    tick();
    bus.execute = 1'b0;
    bus.dataTx  = 1'b0;
  endtask

  // bit index 0 = header, 1..W payload, W+1 parity
  task automatic drive_frame(input logic [W-1:0] pl, input logic pb,
                             input int gap_at, input int gap_len,
                             output logic ferr_any);
    ferr_any = 1'b0;
    for (int b = 0; b < W + 2; b++) begin
      if (b == gap_at) begin
        repeat (gap_len) begin
          bus.execute = 1'b0;
          tick();
          ferr_any |= bus.frame_err;
        end
      end
      if (b == 0) strobe(1'b1);
      else if (b == W + 1) strobe(pb);
      else strobe(pl[b-1]);
      ferr_any |= bus.frame_err;
    end
  endtask

  task automatic test_reset();
    arst = 1'b0;
    bus.isolate = 1'b0;
    bus.execute = 1'b0;
    bus.dataTx = 1'b0;
    bus.rx_ready = 1'b1;
    tick();
    tick();
    total++; if (bus.rx_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.rx_valid); else passed++;
    total++; if (bus.rx_data !== 8'h00) $display("FAIL reset_data got %h want 00", bus.rx_data); else passed++;
    total++; if (bus.rx_perr !== 1'b0) $display("FAIL reset_perr got %b want 0", bus.rx_perr); else passed++;
    total++; if (bus.frame_err !== 1'b0) $display("FAIL reset_ferr got %b want 0", bus.frame_err); else passed++;
    total++; if (bus.overrun !== 1'b0) $display("FAIL reset_ovr got %b want 0", bus.overrun); else passed++;
    arst = 1'b1;
    tick();
  endtask

  task automatic test_valid_frame();
    logic fe;
    bus.rx_ready = 1'b1;
    drive_frame(8'hA5, 1'b0, -1, 0, fe);
    total++; if (bus.rx_valid !== 1'b1) $display("FAIL a5_valid got %b want 1", bus.rx_valid); else passed++;
    total++; if (bus.rx_data !== 8'hA5) $display("FAIL a5_data got %h want a5", bus.rx_data); else passed++;
    total++; if (bus.rx_perr !== 1'b0) $display("FAIL a5_perr got %b want 0", bus.rx_perr); else passed++;
    tick();
    total++; if (bus.rx_valid !== 1'b0) $display("FAIL a5_one_cycle got %b want 0", bus.rx_valid); else passed++;
  endtask

  task automatic test_parity_err();
    logic fe;
    drive_frame(8'h01, 1'b0, -1, 0, fe);
    total++; if (bus.rx_data !== 8'h01) $display("FAIL perr_data got %h want 01", bus.rx_data); else passed++;
    total++; if (bus.rx_perr !== 1'b1) $display("FAIL perr_flag got %b want 1", bus.rx_perr); else passed++;
    tick();
  endtask

  task automatic test_backpressure();
    logic fe;
    bus.rx_ready = 1'b0;
    drive_frame(8'h3C, 1'b0, -1, 0, fe);
    drive_frame(8'hC3, 1'b0, -1, 0, fe);
    total++; if (bus.overrun !== 1'b1) $display("FAIL bp_overrun got %b want 1", bus.overrun); else passed++;
    total++; if (bus.rx_data !== 8'h3C) $display("FAIL bp_held got %h want 3c", bus.rx_data); else passed++;
    total++; if (bus.rx_valid !== 1'b1) $display("FAIL bp_valid got %b want 1", bus.rx_valid); else passed++;
    tick();
    total++; if (bus.overrun !== 1'b0) $display("FAIL bp_ovr_pulse got %b want 0", bus.overrun); else passed++;
    total++; if (bus.rx_data !== 8'h3C) $display("FAIL bp_stable got %h want 3c", bus.rx_data); else passed++;
    bus.rx_ready = 1'b1;
    tick();
    total++; if (bus.rx_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", bus.rx_valid); else passed++;
  endtask

  task automatic test_back_to_back();
    logic fe;
    drive_frame(8'h12, 1'b0, -1, 0, fe);
    total++; if (bus.rx_data !== 8'h12) $display("FAIL b2b_first got %h want 12", bus.rx_data); else passed++;
    strobe(1'b1);
    total++; if (bus.rx_valid !== 1'b0) $display("FAIL b2b_consumed got %b want 0", bus.rx_valid); else passed++;
    for (int i = 0; i < W; i++) strobe(i == 2 || i == 4 || i == 5);
    strobe(1'b1);
    total++; if (bus.rx_data !== 8'h34) $display("FAIL b2b_second got %h want 34", bus.rx_data); else passed++;
    total++; if (bus.rx_perr !== 1'b0) $display("FAIL b2b_perr got %b want 0", bus.rx_perr); else passed++;
    tick();
  endtask

  task automatic test_gap_timeout();
    logic fe;
    logic early;
    strobe(1'b1);
    strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    early = 1'b0;
    repeat (GAP - 1) begin
      tick();
      early |= bus.frame_err;
    end
    total++; if (early !== 1'b0) $display("FAIL gap_early got %b want 0", early); else passed++;
    tick();
    total++; if (bus.frame_err !== 1'b1) $display("FAIL gap_ferr got %b want 1", bus.frame_err); else passed++;
    tick();
    total++; if (bus.frame_err !== 1'b0) $display("FAIL gap_pulse got %b want 0", bus.frame_err); else passed++;
    total++; if (bus.rx_valid !== 1'b0) $display("FAIL gap_nodata got %b want 0", bus.rx_valid); else passed++;
    drive_frame(8'h5A, 1'b0, -1, 0, fe);
    total++; if (bus.rx_data !== 8'h5A) $display("FAIL gap_next got %h want 5a", bus.rx_data); else passed++;
    total++; if (bus.rx_valid !== 1'b1) $display("FAIL gap_next_v got %b want 1", bus.rx_valid); else passed++;
    tick();
  endtask

  task automatic test_gap_boundary();
    logic fe;
    drive_frame(8'h96, 1'b0, 3, GAP - 1, fe);
    total++; if (fe !== 1'b0) $display("FAIL gapb_ferr got %b want 0", fe); else passed++;
    total++; if (bus.rx_data !== 8'h96) $display("FAIL gapb_data got %h want 96", bus.rx_data); else passed++;
    total++; if (bus.rx_valid !== 1'b1) $display("FAIL gapb_valid got %b want 1", bus.rx_valid); else passed++;
    tick();
  endtask

  task automatic test_isolation();
    logic fe;
    int   extra;
    strobe(1'b1);
    for (int i = 0; i < 4; i++) strobe(1'b1);
    bus.isolate = 1'b1;
    tick();
    total++; if (bus.frame_err !== 1'b1) $display("FAIL iso_ferr got %b want 1", bus.frame_err); else passed++;
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      bus.execute = 1'b1;
      bus.dataTx  = (i % 3 != 1);
      tick();
      extra += int'(bus.frame_err) + int'(bus.rx_valid) + int'(bus.overrun);
    end
    total++; if (extra !== 0) $display("FAIL iso_quiet got %0d want 0", extra); else passed++;
    bus.execute = 1'b0;
    bus.isolate = 1'b0;
    tick();
    drive_frame(8'hFF, 1'b0, -1, 0, fe);
    total++; if (bus.rx_data !== 8'hFF) $display("FAIL iso_next got %h want ff", bus.rx_data); else passed++;
    total++; if (bus.rx_perr !== 1'b0) $display("FAIL iso_perr got %b want 0", bus.rx_perr); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    logic fe;
    strobe(1'b1);
    for (int i = 0; i < 5; i++) strobe(1'b0);
    arst = 1'b0;
    tick();
    total++; if (bus.rx_data !== 8'h00) $display("FAIL rmid_data got %h want 00", bus.rx_data); else passed++;
    total++; if (bus.rx_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", bus.rx_valid); else passed++;
    total++; if (bus.frame_err !== 1'b0) $display("FAIL rmid_ferr got %b want 0", bus.frame_err); else passed++;
    arst = 1'b1;
    tick();
    total++; if (bus.frame_err !== 1'b0) $display("FAIL rmid_ferr2 got %b want 0", bus.frame_err); else passed++;
    drive_frame(8'h81, 1'b0, -1, 0, fe);
    total++; if (bus.rx_data !== 8'h81) $display("FAIL rmid_next got %h want 81", bus.rx_data); else passed++;
    total++; if (bus.rx_valid !== 1'b1) $display("FAIL rmid_next_v got %b want 1", bus.rx_valid); else passed++;
    tick();
  endtask

  task automatic test_random();
    bit             s_q[$], d_q[$], l_q[$];
    logic [W-1:0]   f_pl[$];
    logic           f_pb[$];
    logic [W-1:0]   pl, m_data;
    logic           pb, m_perr, m_held, exp_ovr, consumed;
    bit             s, d, l, r;
    int             g;
    for (int f = 0; f < 40; f++) begin
      pl = W'($urandom);
      pb = ($urandom_range(0, 3) == 0) ? ~(^pl) : ^pl;
      f_pl.push_back(pl);
      f_pb.push_back(pb);
      for (int b = 0; b < W + 2; b++) begin
        g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, GAP - 2) : 0;
        repeat (g) begin
          s_q.push_back(1'b0);
          d_q.push_back(1'($urandom_range(0, 1)));
          l_q.push_back(1'b0);
        end
        if (b == 0 && $urandom_range(0, 2) == 0) begin
          s_q.push_back(1'b1);
          d_q.push_back(1'b0);
          l_q.push_back(1'b0);
        end
        s_q.push_back(1'b1);
        d_q.push_back(b == 0 ? 1'b1 : (b == W + 1 ? pb : pl[b-1]));
        l_q.push_back(b == W + 1);
      end
    end
    m_held = 1'b0;
    m_data = '0;
    m_perr = 1'b0;
    while (s_q.size() > 0) begin
      s = s_q.pop_front();
      d = d_q.pop_front();
      l = l_q.pop_front();
      r = 1'($urandom_range(0, 1));
      bus.execute  = s;
      bus.dataTx   = d;
      bus.rx_ready = r;
      consumed = m_held && r;
      exp_ovr  = 1'b0;
      if (l) begin
        pl = f_pl.pop_front();
        pb = f_pb.pop_front();
        if (!m_held || consumed) begin
          m_held = 1'b1;
          m_data = pl;
          m_perr = (^pl) ^ pb;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (consumed) begin
        m_held = 1'b0;
      end
      tick();
      total++; if (bus.rx_valid !== m_held) $display("FAIL rnd_valid got %b want %b", bus.rx_valid, m_held); else passed++;
      if (m_held) begin
        total++; if (bus.rx_data !== m_data) $display("FAIL rnd_data got %h want %h", bus.rx_data, m_data); else passed++;
        total++; if (bus.rx_perr !== m_perr) $display("FAIL rnd_perr got %b want %b", bus.rx_perr, m_perr); else passed++;
      end
      total++; if (bus.overrun !== exp_ovr) $display("FAIL rnd_ovr got %b want %b", bus.overrun, exp_ovr); else passed++;
      total++; if (bus.frame_err !== 1'b0) $display("FAIL rnd_ferr got %b want 0", bus.frame_err); else passed++;
    end
    bus.execute  = 1'b0;
    bus.rx_ready = 1'b1;
    tick();
    total++; if (bus.rx_valid !== 1'b0) $display("FAIL rnd_drain got %b want 0", bus.rx_valid); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    arst   = 1'b0;
    test_reset();
    test_valid_frame();
    test_parity_err();
    test_backpressure();
    test_back_to_back();
    test_gap_timeout();
    test_gap_boundary();
    test_isolation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
